m_cp0_exc_handler: RTL and testbench

M_CP0_EXC_HANDLER -- requirements
Module: m_cp0_exc_handler

---
 rtl/m_cp0_exc_handler.sv | 161 ++++++++++++++++
 tb/tb_m_cp0_exc_handler.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/m_cp0_exc_handler.sv
// m_cp0_exc_handler: CP0 exception/interrupt front end for a MIPS-style pipeline.
// Holds SR, Cause and EPC. It raises a combinational redirect request for an
// interrupt or an exception in the M stage, and services mtc0 writes and eret.
// Optional feature macro: CP0_TIMER_EN adds Count (reg 9), Compare (reg 11) and
// a timer interrupt, which is ORed into Cause.IP[15].
module m_cp0_exc_handler (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    output logic [31:0] cp0_rdata,
    input  logic [31:0] vpc,
    input  logic        bd_in,
    input  logic [4:0]  exc_code_in,
    input  logic [5:0]  hw_int,
    input  logic        eret,
    output logic        req,
    output logic [31:0] epc_out
);

    localparam logic [4:0] ADDR_COUNT   = 5'd9;
    localparam logic [4:0] ADDR_COMPARE = 5'd11;
    localparam logic [4:0] ADDR_SR      = 5'd12;
    localparam logic [4:0] ADDR_CAUSE   = 5'd13;
    localparam logic [4:0] ADDR_EPC     = 5'd14;

    // Architectural state
    logic [5:0]  sr_im_q,     sr_im_d;
    logic        sr_exl_q,    sr_exl_d;
    logic        sr_ie_q,     sr_ie_d;
    logic        cause_bd_q,  cause_bd_d;
    logic [5:0]  cause_ip_q,  cause_ip_d;
    logic [4:0]  cause_exc_q, cause_exc_d;
    logic [31:0] epc_q,       epc_d;

`ifdef CP0_TIMER_EN
    logic [31:0] count_q,     count_d;
    logic [31:0] compare_q,   compare_d;
    logic        tpend_q,     tpend_d;
`endif

    logic [5:0] ip_now;
    logic       int_req;
    logic       exc_req;
    logic       mtc0_ok;

    // Pending interrupt lines seen this cycle (external plus timer)
`ifdef CP0_TIMER_EN
    always_comb begin
        ip_now = {hw_int[5] | tpend_q, hw_int[4:0]};
    end
`else
    always_comb begin
        ip_now = hw_int;
    end
`endif

    // Request generation: interrupts and exceptions are blocked while EXL is set
    always_comb begin
        int_req = (|(ip_now & sr_im_q)) & sr_ie_q & ~sr_exl_q;
        exc_req = (exc_code_in != 5'd0) & ~sr_exl_q;
        req     = int_req | exc_req;
        // A write is dropped when the instruction is being flushed, and eret
        // leaves all state except EXL untouched.
        mtc0_ok = en & ~req & ~eret;
    end

    // Next-state: exception entry, eret, mtc0 writes
    always_comb begin
        sr_im_d     = sr_im_q;
        sr_exl_d    = sr_exl_q;
        sr_ie_d     = sr_ie_q;
        cause_bd_d  = cause_bd_q;
        cause_ip_d  = ip_now;
        cause_exc_d = cause_exc_q;
        epc_d       = epc_q;

        if (req) begin
            sr_exl_d    = 1'b1;
            cause_bd_d  = bd_in;
            cause_exc_d = int_req ? 5'd0 : exc_code_in;
            epc_d       = bd_in ? (vpc - 32'd4) : vpc;
        end else if (eret) begin
            sr_exl_d    = 1'b0;
        end else if (en) begin
            if (cp0_addr == ADDR_SR) begin
                sr_im_d  = cp0_wdata[15:10];
                sr_exl_d = cp0_wdata[1];
                sr_ie_d  = cp0_wdata[0];
            end
            if (cp0_addr == ADDR_EPC) begin
                epc_d = cp0_wdata;
            end
        end
    end

`ifdef CP0_TIMER_EN
    // Timer next-state: free-running Count, match sets pending, Compare write clears it
    always_comb begin
        count_d   = count_q + 32'd1;
        compare_d = compare_q;
        tpend_d   = tpend_q | (count_q == compare_q);
        if (mtc0_ok && (cp0_addr == ADDR_COUNT)) begin
            count_d = cp0_wdata;
        end
        if (mtc0_ok && (cp0_addr == ADDR_COMPARE)) begin
            compare_d = cp0_wdata;
            tpend_d   = 1'b0;
        end
    end
`endif

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            sr_im_q     <= 6'd0;
            sr_exl_q    <= 1'b0;
            sr_ie_q     <= 1'b0;
            cause_bd_q  <= 1'b0;
            cause_ip_q  <= 6'd0;
            cause_exc_q <= 5'd0;
            epc_q       <= 32'd0;
`ifdef CP0_TIMER_EN
            count_q     <= 32'd0;
            compare_q   <= 32'd0;
            tpend_q     <= 1'b0;
`endif
        end else begin
            sr_im_q     <= sr_im_d;
            sr_exl_q    <= sr_exl_d;
            sr_ie_q     <= sr_ie_d;
            cause_bd_q  <= cause_bd_d;
            cause_ip_q  <= cause_ip_d;
            cause_exc_q <= cause_exc_d;
            epc_q       <= epc_d;
`ifdef CP0_TIMER_EN
            count_q     <= count_d;
            compare_q   <= compare_d;
            tpend_q     <= tpend_d;
`endif
        end
    end

    // Combinational register read; unmapped numbers read as zero
    always_comb begin
        cp0_rdata = 32'd0;
        case (cp0_addr)
            ADDR_SR:    cp0_rdata = {16'd0, sr_im_q, 8'd0, sr_exl_q, sr_ie_q};
            ADDR_CAUSE: cp0_rdata = {cause_bd_q, 15'd0, cause_ip_q, 3'd0, cause_exc_q, 2'd0};
            ADDR_EPC:   cp0_rdata = epc_q;
`ifdef CP0_TIMER_EN
            ADDR_COUNT:   cp0_rdata = count_q;
            ADDR_COMPARE: cp0_rdata = compare_q;
`endif
            default:    cp0_rdata = 32'd0;
        endcase
        epc_out = epc_q;
    end

endmodule

// File: tb/tb_m_cp0_exc_handler.sv
// Directed bench for m_cp0_exc_handler. Timer steps are compiled only with CP0_TIMER_EN.
module tb_m_cp0_exc_handler;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic [31:0] vpc;
    logic        bd_in;
    logic [4:0]  exc_code_in;
    logic [5:0]  hw_int;
    logic        eret;
    logic        req;
    logic [31:0] epc_out;

    int vectors = 0;
    int miscompares = 0;

    m_cp0_exc_handler dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .cp0_addr    (cp0_addr),
        .cp0_wdata   (cp0_wdata),
        .cp0_rdata   (cp0_rdata),
        .vpc         (vpc),
        .bd_in       (bd_in),
        .exc_code_in (exc_code_in),
        .hw_int      (hw_int),
        .eret        (eret),
        .req         (req),
        .epc_out     (epc_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
        cp0_addr = a;
        #1;
        check(tag, cp0_rdata, exp);
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; cp0_addr = 5'd0; cp0_wdata = 32'd0;
        vpc = 32'd0; bd_in = 1'b0; exc_code_in = 5'd0; hw_int = 6'h3F; eret = 1'b0;

        // Reset: interrupts masked while IE=0
        step(); step();
        check("reset_req_masked", {31'd0, req}, 32'd0);
        hw_int = 6'd0;
        reset = 1'b1;
        #1;
        rd("reset_sr", 5'd12, 32'h0000_0000);
        rd("reset_cause", 5'd13, 32'h0000_0000);
        rd("reset_epc", 5'd14, 32'h0000_0000);
        check("reset_epc_out", epc_out, 32'h0000_0000);
        check("idle_req", {31'd0, req}, 32'd0);
`ifndef CP0_TIMER_EN
        rd("unmapped_count", 5'd9, 32'h0000_0000);
`endif

        // mtc0 SR keeps only IM/EXL/IE
        en = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'hFFFF_0401;
        step();
        en = 1'b0;
        rd("sr_write_mask", 5'd12, 32'h0000_0401);

        // Interrupt entry
        vpc = 32'h0000_1000; hw_int = 6'b000001;
        #1;
        check("int_req", {31'd0, req}, 32'd1);
        step();
        rd("int_cause", 5'd13, 32'h0000_0400);
        rd("int_sr_exl", 5'd12, 32'h0000_0403);
        check("int_epc", epc_out, 32'h0000_1000);
        check("exl_blocks_int", {31'd0, req}, 32'd0);
        hw_int = 6'd0;
        eret = 1'b1;
        #1;
        check("eret_no_req", {31'd0, req}, 32'd0);
        step();
        eret = 1'b0;
        rd("eret_sr", 5'd12, 32'h0000_0401);

        // Exception in a delay slot
        exc_code_in = 5'd12; bd_in = 1'b1; vpc = 32'h0000_3010;
        #1;
        check("exc_req", {31'd0, req}, 32'd1);
        step();
        bd_in = 1'b0;
        rd("exc_cause", 5'd13, 32'h8000_0030);
        check("exc_epc_bd", epc_out, 32'h0000_300C);
        rd("exc_sr", 5'd12, 32'h0000_0403);

        // EXL blocks everything; eret re-enables
        hw_int = 6'h3F;
        #1;
        check("exl_blocks_all", {31'd0, req}, 32'd0);
        eret = 1'b1;
        step();
        eret = 1'b0;
        #1;
        check("req_after_eret", {31'd0, req}, 32'd1);
        rd("eret_sr2", 5'd12, 32'h0000_0401);
        rd("eret_cause_kept", 5'd13, 32'h8000_FC30);
        check("eret_epc_kept", epc_out, 32'h0000_300C);

        // Interrupt wins over pending exception
        vpc = 32'h0000_2000;
        step();
        rd("prio_cause", 5'd13, 32'h0000_FC00);
        check("prio_epc", epc_out, 32'h0000_2000);
        exc_code_in = 5'd0; hw_int = 6'd0;
        eret = 1'b1;
        step();
        eret = 1'b0;

        // mtc0 EPC dropped when an exception is taken the same cycle
        en = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h0000_1234;
        exc_code_in = 5'd10; vpc = 32'h0000_4000;
        #1;
        check("drop_req", {31'd0, req}, 32'd1);
        step();
        en = 1'b0; exc_code_in = 5'd0;
        check("drop_epc", epc_out, 32'h0000_4000);
        rd("drop_cause", 5'd13, 32'h0000_0028);
        eret = 1'b1;
        step();
        eret = 1'b0;

        // mtc0 EPC accepted, no bypass to epc_out
        en = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'hCAFE_F00D;
        #1;
        check("epc_no_bypass", epc_out, 32'h0000_4000);
        step();
        en = 1'b0;
        check("epc_write", epc_out, 32'hCAFE_F00D);

        // Cause is read-only
        en = 1'b1; cp0_addr = 5'd13; cp0_wdata = 32'hFFFF_FFFF;
        step();
        en = 1'b0;
        rd("cause_ro", 5'd13, 32'h0000_0028);

        // EPC wraps for delay slot at address 0
        vpc = 32'h0000_0000; bd_in = 1'b1; exc_code_in = 5'd4;
        step();
        bd_in = 1'b0; exc_code_in = 5'd0;
        check("epc_wrap", epc_out, 32'hFFFF_FFFC);
        rd("wrap_cause", 5'd13, 32'h8000_0010);

        // Reset overrides a simultaneous mtc0
        en = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0401; reset = 1'b0;
        step();
        en = 1'b0; reset = 1'b1;
        rd("rst_ovr_sr", 5'd12, 32'h0000_0000);
        rd("rst_ovr_cause", 5'd13, 32'h0000_0000);
        check("rst_ovr_epc", epc_out, 32'h0000_0000);
        hw_int = 6'h3F;
        #1;
        check("rst_int_masked", {31'd0, req}, 32'd0);
        exc_code_in = 5'd3;
        #1;
        check("rst_exc_req", {31'd0, req}, 32'd1);
        hw_int = 6'd0; exc_code_in = 5'd0;

`ifdef CP0_TIMER_EN
        // Timer: Count=0, Compare=5, SR=IM7|IE
        en = 1'b1; cp0_addr = 5'd9; cp0_wdata = 32'd0;
        step();
        cp0_addr = 5'd11; cp0_wdata = 32'd5;
        step();
        cp0_addr = 5'd12; cp0_wdata = 32'h0000_8001;
        step();
        en = 1'b0;
        rd("tmr_count2", 5'd9, 32'd2);
        rd("tmr_compare", 5'd11, 32'd5);
        check("tmr_no_req", {31'd0, req}, 32'd0);
        step(); step(); step();
        rd("tmr_count5", 5'd9, 32'd5);
        check("tmr_no_req5", {31'd0, req}, 32'd0);
        step();
        check("tmr_req", {31'd0, req}, 32'd1);
        step();
        en = 1'b1; cp0_addr = 5'd11; cp0_wdata = 32'd100;
        step();
        en = 1'b0;
        eret = 1'b1;
        step();
        eret = 1'b0;
        #1;
        check("tmr_cleared", {31'd0, req}, 32'd0);
        rd("tmr_compare100", 5'd11, 32'd100);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
